mig_request_responder: RTL and testbench

- Responder end of the core-side device memory request interface (device_addr / read_en / write_en / data_out / data_in).
- Converts single 32-bit word requests from the arbitrated core into ExternalMemory (MIG DDR3) app-interface commands.
- Returns read data and a completion pulse to the core side.
- Clocked by the MIG ui_clk; sits between the core arbiter mux and ExternalMemory.

---
 rtl/mig_request_responder_if.sv | 42 ++++
 rtl/mig_request_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_mig_request_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mig_request_responder_if.sv
// Core-side device request bus and MIG app-interface signals around mig_request_responder.
// slave = responder view, master = core arbiter / MIG side view.
interface mig_request_responder_if #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned APP_MASK_WIDTH = 16
);
    logic                      init_calib_complete;
    logic [31:0]               device_addr;
    logic                      device_read_en;
    logic                      device_write_en;
    logic [31:0]               device_data_out;
    logic [31:0]               device_data_in;
    logic                      device_ack;
    logic                      device_error;
    logic                      device_busy;
    logic [ADDR_WIDTH-1:0]     app_addr;
    logic [2:0]                app_cmd;
    logic                      app_en;
    logic                      app_rdy;
    logic [APP_DATA_WIDTH-1:0] app_wdf_data;
    logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
    logic                      app_wdf_wren;
    logic                      app_wdf_end;
    logic                      app_wdf_rdy;
    logic [APP_DATA_WIDTH-1:0] app_rd_data;
    logic                      app_rd_data_valid;

    modport slave (
        input  init_calib_complete, device_addr, device_read_en, device_write_en,
               device_data_out, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output device_data_in, device_ack, device_error, device_busy, app_addr, app_cmd,
               app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport master (
        output init_calib_complete, device_addr, device_read_en, device_write_en,
               device_data_out, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  device_data_in, device_ack, device_error, device_busy, app_addr, app_cmd,
               app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );
endinterface

// File: rtl/mig_request_responder.sv
// Turns single 32-bit core word requests into MIG DDR3 app-interface commands.
// Define RESP_LINE_BUFFER_EN to add a one-line read buffer in front of the MIG.
module mig_request_responder #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned APP_MASK_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic                    clk,
    input logic                    reset,
    mig_request_responder_if.slave bus
);
    localparam int unsigned     CntW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned     TagW     = ADDR_WIDTH - 3;
    localparam logic [2:0]      CmdWrite = 3'b000;
    localparam logic [2:0]      CmdRead  = 3'b001;
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StWrite, StRcmd, StRwait, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [1:0]                lane_q, lane_d;
    logic                      cmd_ok_q, cmd_ok_d, dat_ok_q, dat_ok_d;
    logic [31:0]               data_in_q, data_in_d;
    logic                      ack_q, ack_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [2:0]                cmd_q, cmd_d;
    logic                      en_q, en_d, wren_q, wren_d;
    logic [APP_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APP_MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic                      timeout;
    logic                      unused_addr;

    assign unused_addr = ^{bus.device_addr[31:ADDR_WIDTH+1], bus.device_addr[1:0]};
    assign timeout     = (cnt_q == CntLast);

`ifdef RESP_LINE_BUFFER_EN
    logic [APP_DATA_WIDTH-1:0] line_q, line_d;
    logic [TagW-1:0]           tag_q, tag_d;
    logic                      lvalid_q, lvalid_d;
    logic                      rd_hit, wr_hit;

    assign rd_hit = lvalid_q && (tag_q == bus.device_addr[ADDR_WIDTH:4]);
    assign wr_hit = lvalid_q && (tag_q == addr_q[ADDR_WIDTH-1:3]);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        lane_d    = lane_q;
        cmd_ok_d  = cmd_ok_q;
        dat_ok_d  = dat_ok_q;
        data_in_d = data_in_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        en_d      = en_q;
        wren_d    = wren_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
`ifdef RESP_LINE_BUFFER_EN
        line_d    = line_q;
        tag_d     = tag_q;
        lvalid_d  = lvalid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.init_calib_complete && (bus.device_write_en || bus.device_read_en)) begin
                    addr_d = {bus.device_addr[ADDR_WIDTH:4], 3'b000};
                    lane_d = bus.device_addr[3:2];
                    if (bus.device_write_en) begin
                        cmd_d    = CmdWrite;
                        wdata_d  = {(APP_DATA_WIDTH/32){bus.device_data_out}};
                        wmask_d  = ~({{(APP_MASK_WIDTH-4){1'b0}}, 4'hF} << {bus.device_addr[3:2], 2'b00});
                        en_d     = 1'b1;
                        wren_d   = 1'b1;
                        cmd_ok_d = 1'b0;
                        dat_ok_d = 1'b0;
                        state_d  = StWrite;
                    end else begin
                        cmd_d   = CmdRead;
                        en_d    = 1'b1;
                        state_d = StRcmd;
`ifdef RESP_LINE_BUFFER_EN
                        if (rd_hit) begin
                            data_in_d = line_q[32*bus.device_addr[3:2] +: 32];
                            ack_d     = 1'b1;
                            en_d      = 1'b0;
                            state_d   = StDone;
                        end
`endif
                    end
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 1'b1;
                // Command and data channels are accepted independently.
                if (en_q && bus.app_rdy) begin
                    en_d     = 1'b0;
                    cmd_ok_d = 1'b1;
                end
                if (wren_q && bus.app_wdf_rdy) begin
                    wren_d   = 1'b0;
                    dat_ok_d = 1'b1;
                end
                if (cmd_ok_q && dat_ok_q) begin
                    ack_d   = 1'b1;
                    state_d = StDone;
`ifdef RESP_LINE_BUFFER_EN
                    if (wr_hit) line_d[32*lane_q +: 32] = wdata_q[31:0];
`endif
                end else if (timeout) begin
                    en_d    = 1'b0;
                    wren_d  = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDone;
`ifdef RESP_LINE_BUFFER_EN
                    lvalid_d = 1'b0;
`endif
                end
            end
            StRcmd: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.app_rdy) begin
                    en_d    = 1'b0;
                    state_d = StRwait;
                end else if (timeout) begin
                    en_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDone;
`ifdef RESP_LINE_BUFFER_EN
                    lvalid_d = 1'b0;
`endif
                end
            end
            StRwait: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.app_rd_data_valid) begin
                    data_in_d = bus.app_rd_data[32*lane_q +: 32];
                    ack_d     = 1'b1;
                    state_d   = StDone;
`ifdef RESP_LINE_BUFFER_EN
                    line_d   = bus.app_rd_data;
                    tag_d    = addr_q[ADDR_WIDTH-1:3];
                    lvalid_d = 1'b1;
`endif
                end else if (timeout) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = StDone;
`ifdef RESP_LINE_BUFFER_EN
                    lvalid_d = 1'b0;
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            lane_q    <= '0;
            cmd_ok_q  <= 1'b0;
            dat_ok_q  <= 1'b0;
            data_in_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            cmd_q     <= '0;
            en_q      <= 1'b0;
            wren_q    <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            cmd_ok_q  <= cmd_ok_d;
            dat_ok_q  <= dat_ok_d;
            data_in_q <= data_in_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            en_q      <= en_d;
            wren_q    <= wren_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

`ifdef RESP_LINE_BUFFER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q   <= '0;
            tag_q    <= '0;
            lvalid_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            tag_q    <= tag_d;
            lvalid_q <= lvalid_d;
        end
    end
`endif

    assign bus.device_data_in = data_in_q;
    assign bus.device_ack     = ack_q;
    assign bus.device_error   = err_q;
    assign bus.device_busy    = (state_q != StIdle) || !bus.init_calib_complete;
    assign bus.app_addr       = addr_q;
    assign bus.app_cmd        = cmd_q;
    assign bus.app_en         = en_q;
    assign bus.app_wdf_data   = wdata_q;
    assign bus.app_wdf_mask   = wmask_q;
    assign bus.app_wdf_wren   = wren_q;
    assign bus.app_wdf_end    = 1'b1;
endmodule

// File: tb/tb_mig_request_responder.sv
// Directed bench for mig_request_responder: calibration gate, write, read, split handshake,
// timeout, mid-operation reset and (with RESP_LINE_BUFFER_EN) a line-buffer hit.
module tb_mig_request_responder;
    localparam int unsigned Timeout = 1023;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_en;

    mig_request_responder_if #(
        .ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)
    ) bus ();

    mig_request_responder #(
        .ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16), .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.init_calib_complete = 1'b0;
        bus.device_addr         = '0;
        bus.device_read_en      = 1'b0;
        bus.device_write_en     = 1'b0;
        bus.device_data_out     = '0;
        bus.app_rdy             = 1'b0;
        bus.app_wdf_rdy         = 1'b0;
        bus.app_rd_data         = '0;
        bus.app_rd_data_valid   = 1'b0;
        step();
        step();
        check("rst_data_in", bus.device_data_in, 0);
        check("rst_ack", bus.device_ack, 0);
        check("rst_err", bus.device_error, 0);
        check("rst_addr", bus.app_addr, 0);
        check("rst_cmd", bus.app_cmd, 0);
        check("rst_en", bus.app_en, 0);
        check("rst_wdata", bus.app_wdf_data, 0);
        check("rst_mask", bus.app_wdf_mask, 16'hFFFF);
        check("rst_wren", bus.app_wdf_wren, 0);
        check("wdf_end", bus.app_wdf_end, 1);
        reset = 1'b1;

        // Calibration gate, then write 0x24 with both readies high
        bus.device_addr     = 32'h0000_0024;
        bus.device_data_out = 32'hDEAD_BEEF;
        bus.device_write_en = 1'b1;
        bus.app_rdy         = 1'b1;
        bus.app_wdf_rdy     = 1'b1;
        step(); step(); step();
        check("gate_en", bus.app_en, 0);
        check("gate_wren", bus.app_wdf_wren, 0);
        check("gate_busy", bus.device_busy, 1);
        bus.init_calib_complete = 1'b1;
        step();
        check("wr_en", bus.app_en, 1);
        check("wr_wren", bus.app_wdf_wren, 1);
        check("wr_addr", bus.app_addr, 28'h10);
        check("wr_cmd", bus.app_cmd, 3'b000);
        check("wr_data", bus.app_wdf_data, {4{32'hDEAD_BEEF}});
        check("wr_mask", bus.app_wdf_mask, 16'hFF0F);
        check("wr_busy", bus.device_busy, 1);
        step();
        check("wr_en_drop", bus.app_en, 0);
        check("wr_wren_drop", bus.app_wdf_wren, 0);
        check("wr_ack_early", bus.device_ack, 0);
        step();
        check("wr_ack", bus.device_ack, 1);
        check("wr_err", bus.device_error, 0);
        bus.device_write_en = 1'b0;
        step();
        check("wr_ack_pulse", bus.device_ack, 0);
        check("idle_busy", bus.device_busy, 0);

        // Read 0x28, data returned some cycles after command acceptance
        bus.device_addr    = 32'h0000_0028;
        bus.device_read_en = 1'b1;
        step();
        check("rd_en", bus.app_en, 1);
        check("rd_cmd", bus.app_cmd, 3'b001);
        check("rd_addr", bus.app_addr, 28'h10);
        step();
        check("rd_en_drop", bus.app_en, 0);
        step(); step(); step();
        check("rd_ack_early", bus.device_ack, 0);
        bus.app_rd_data       = 128'h11111111_22222222_33333333_44444444;
        bus.app_rd_data_valid = 1'b1;
        step();
        check("rd_ack", bus.device_ack, 1);
        check("rd_data", bus.device_data_in, 32'h2222_2222);
        bus.app_rd_data_valid = 1'b0;
        bus.device_read_en    = 1'b0;
        step();
        check("rd_ack_pulse", bus.device_ack, 0);
        check("rd_data_hold", bus.device_data_in, 32'h2222_2222);

        // Split write handshake to lane 3; write wins over a simultaneous read
        bus.device_addr     = 32'h0000_000C;
        bus.device_data_out = 32'hCAFE_F00D;
        bus.device_write_en = 1'b1;
        bus.device_read_en  = 1'b1;
        bus.app_rdy         = 1'b0;
        step();
        check("sp_cmd", bus.app_cmd, 3'b000);
        check("sp_mask", bus.app_wdf_mask, 16'h0FFF);
        check("sp_data", bus.app_wdf_data, {4{32'hCAFE_F00D}});
        check("sp_addr", bus.app_addr, 28'h0);
        step();
        check("sp_wren_drop", bus.app_wdf_wren, 0);
        check("sp_en_held", bus.app_en, 1);
        step(); step(); step();
        check("sp_en_held2", bus.app_en, 1);
        check("sp_no_ack", bus.device_ack, 0);
        bus.app_rdy = 1'b1;
        step();
        check("sp_en_drop", bus.app_en, 0);
        check("sp_ack_early", bus.device_ack, 0);
        step();
        check("sp_ack", bus.device_ack, 1);
        bus.device_write_en = 1'b0;
        bus.device_read_en  = 1'b0;
        step();
        check("sp_ack_pulse", bus.device_ack, 0);

        // Command timeout on a read that is never accepted
        bus.device_addr    = 32'h0000_0040;
        bus.device_read_en = 1'b1;
        bus.app_rdy        = 1'b0;
        step();
        n_en = 0;
        while (bus.app_en && n_en < Timeout + 10) begin
            n_en++;
            step();
        end
        check("to_en_cycles", n_en, Timeout);
        check("to_ack", bus.device_ack, 1);
        check("to_err", bus.device_error, 1);
        check("to_data", bus.device_data_in, 32'h2222_2222);
        bus.device_read_en = 1'b0;
        step();
        check("to_ack_pulse", bus.device_ack, 0);
        check("to_err_pulse", bus.device_error, 0);
        bus.app_rd_data       = 128'h99999999_88888888_77777777_66666666;
        bus.app_rd_data_valid = 1'b1;
        step();
        bus.app_rd_data_valid = 1'b0;
        step();
        check("stray_data", bus.device_data_in, 32'h2222_2222);
        check("stray_ack", bus.device_ack, 0);
        check("stray_busy", bus.device_busy, 0);

        // Reset in the middle of a write
        bus.device_addr     = 32'h0000_0004;
        bus.device_write_en = 1'b1;
        step();
        check("mr_en_pre", bus.app_en, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_en", bus.app_en, 0);
        check("mr_wren", bus.app_wdf_wren, 0);
        check("mr_mask", bus.app_wdf_mask, 16'hFFFF);
        check("mr_data_in", bus.device_data_in, 0);
        bus.device_write_en = 1'b0;
        step();
        reset   = 1'b1;
        bus.app_rdy = 1'b1;
        step();
        step();
        check("mr_no_ack", bus.device_ack, 0);

`ifdef RESP_LINE_BUFFER_EN
        // Miss on 0x20 fills the line; 0x2C then hits without a MIG command
        bus.device_addr    = 32'h0000_0020;
        bus.device_read_en = 1'b1;
        step();
        check("lb_miss_en", bus.app_en, 1);
        step();
        bus.app_rd_data       = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
        bus.app_rd_data_valid = 1'b1;
        step();
        check("lb_miss_data", bus.device_data_in, 32'hAAAA_0000);
        bus.app_rd_data_valid = 1'b0;
        bus.device_read_en    = 1'b0;
        step();
        bus.device_addr    = 32'h0000_002C;
        bus.device_read_en = 1'b1;
        step();
        check("lb_hit_en", bus.app_en, 0);
        check("lb_hit_ack", bus.device_ack, 1);
        check("lb_hit_data", bus.device_data_in, 32'hAAAA_0003);
        bus.device_read_en = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
